// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush generation, EX operand forwarding, load-use
// detection and data-memory wait sequencing for the 5-stage core.
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              MemReadE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  StallCount,
  output logic              MemTimeout
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERROR    = 2'd2;

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] waitcnt;
  logic [7:0] waitcnt_nxt;
  logic       lw_stall;
  logic       mem_stall;

  // Forward select for one EX source register; MEM result is the newest, so it wins.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs))
      return 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign lw_stall  = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = MemReqM && !MemReadyM;

  // Control outputs: reset forcing, then error freeze, memory freeze, or normal hazard rules.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
      if ((state == ERROR) || mem_stall) begin
        // Whole pipe frozen; WB gets a bubble so nothing retires twice.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        // A taken branch discards the wrong-path ID instruction rather than holding it.
        StallF = lw_stall && !PCSrcE;
        StallD = lw_stall && !PCSrcE;
        FlushD = PCSrcE;
        FlushE = lw_stall || PCSrcE;
      end
    end
  end

  // Next state and wait counter for the memory wait sequencer.
  always_comb begin
    state_nxt   = state;
    waitcnt_nxt = waitcnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt   = MEM_WAIT;
          waitcnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        // A dropped request counts as completion.
        if (!mem_stall) begin
          state_nxt   = RUN;
          waitcnt_nxt = 8'd0;
        end else if (waitcnt == TIMEOUT_LIM) begin
          state_nxt = ERROR;
        end else begin
          waitcnt_nxt = waitcnt + 8'd1;
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt   = RUN;
        waitcnt_nxt = 8'd0;
      end
    endcase
  end

  // State, wait counter, sticky timeout flag and stall-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      waitcnt    <= 8'd0;
      StallCount <= '0;
      MemTimeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      waitcnt    <= waitcnt_nxt;
      MemTimeout <= MemTimeout || (state_nxt == ERROR);
      if (StallF)
        StallCount <= sat_inc(StallCount);
    end
  end

endmodule
